// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing the VGAGenerator VRAM write port between the
// FFT sample writer (req0) and the overlay writer (req1), gated by vertical blank.
module vram_write_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vblank,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_writes
);

    localparam int unsigned      BURST_W   = 4;
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_SAT = '1;
    localparam logic [CNT_W-1:0]   CNT_SAT   = '1;

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 vb_q;
    logic                 last_grant;
    logic [BURST_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]     wr_cnt;
    logic [CNT_W-1:0]     wr_cnt_inc;
    logic                 grant0;
    logic                 grant1;
    logic                 pick1;
    logic                 fire;
    logic                 winner;
    logic                 closing;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLOSED;
        end else begin
            state <= state_nx;
        end
    end

    // Window transitions and grant selection; burst_cnt==0 marks a fresh
    // window, where a tie goes to the requester opposite last_grant.
    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        pick1    = 1'b0;
        case (state)
            CLOSED:  if (vb_q)  state_nx = OPEN;
            OPEN:    if (!vb_q) state_nx = CLOSED;
            default: state_nx = CLOSED;
        endcase
        if (state == OPEN) begin
            if (req0_valid && req1_valid) begin
                if ((burst_cnt != '0) && (burst_cnt < BURST_LIM)) begin
                    pick1 = last_grant;
                end else begin
                    pick1 = ~last_grant;
                end
                grant1 = pick1;
                grant0 = ~pick1;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state == OPEN);
    assign fire       = grant0 | grant1;
    assign winner     = grant1;
    assign closing    = (state == OPEN) && !vb_q;
    assign wr_cnt_inc = (wr_cnt == CNT_SAT) ? wr_cnt : wr_cnt + CNT_W'(1);

    // Datapath: write strobe, burst tracking and per-window write count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vb_q         <= 1'b0;
            vram_we      <= 1'b0;
            vram_addr    <= '0;
            vram_data    <= '0;
            last_grant   <= 1'b1;
            burst_cnt    <= '0;
            wr_cnt       <= '0;
            frame_writes <= '0;
        end else begin
            vb_q    <= vblank;
            vram_we <= fire;
            if (fire) begin
                vram_addr <= winner ? req1_addr : req0_addr;
                vram_data <= winner ? req1_data : req0_data;
                wr_cnt    <= wr_cnt_inc;
                if (winner == last_grant) begin
                    burst_cnt <= (burst_cnt == BURST_SAT) ? burst_cnt
                                                          : burst_cnt + BURST_W'(1);
                end else begin
                    last_grant <= winner;
                    burst_cnt  <= BURST_W'(1);
                end
            end
            if (closing) begin
                frame_writes <= fire ? wr_cnt_inc : wr_cnt;
                wr_cnt       <= '0;
                burst_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: a MAX_BURST=4 and a MAX_BURST=1
// instance share one stimulus; a vector table plus hand-written corner sequences.
module tb_vram_write_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam logic [AW-1:0] A0 = 10'h0A0;
    localparam logic [AW-1:0] A1 = 10'h0B1;
    localparam logic [DW-1:0] D0 = 16'hA000;
    localparam logic [DW-1:0] D1 = 16'hB111;

    logic          clock;
    logic          reset_n;
    logic          vblank;
    logic          v0;
    logic          v1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;

    logic          r0_4, r1_4, we_4, busy_4;
    logic [AW-1:0] addr_4;
    logic [DW-1:0] data_4;
    logic [CW-1:0] fw_4;
    logic          r0_1, r1_1, we_1, busy_1;
    logic [AW-1:0] addr_1;
    logic [DW-1:0] data_1;
    logic [CW-1:0] fw_1;

    int n_cmp;
    int n_fail;

    vram_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4), .CNT_W(CW)) dut4 (
        .clock(clock), .reset_n(reset_n), .vblank(vblank),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_4),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_4),
        .vram_we(we_4), .vram_addr(addr_4), .vram_data(data_4),
        .busy(busy_4), .frame_writes(fw_4)
    );

    vram_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1), .CNT_W(CW)) dut1 (
        .clock(clock), .reset_n(reset_n), .vblank(vblank),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_1),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_1),
        .vram_we(we_1), .vram_addr(addr_1), .vram_data(data_1),
        .busy(busy_1), .frame_writes(fw_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // g4/g1: expected grant per instance (0 none, 1 req0, 2 req1)
    typedef struct {
        int vb;
        int rv0;
        int rv1;
        int bsy;
        int g4;
        int g1;
    } vec_t;

    localparam int NV = 29;
    vec_t vt[NV];
    int   pat4[20];
    int   pat1[20];

    initial begin
        logic [AW-1:0] ea4, ea1;
        logic [DW-1:0] ed4, ed1;
        int            pg4, pg1;
        int            bad;

        n_cmp  = 0;
        n_fail = 0;
        pat4 = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
        pat1 = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
        vt[0] = '{1, 1, 1, 0, 0, 0};
        vt[1] = '{1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 20; i++) vt[2 + i] = '{1, 1, 1, 1, pat4[i], pat1[i]};
        for (int i = 22; i < 26; i++) vt[i] = '{1, 1, 0, 1, 1, 1};
        vt[26] = '{0, 0, 0, 1, 0, 0};
        vt[27] = '{0, 0, 0, 1, 0, 0};
        vt[28] = '{0, 0, 0, 0, 0, 0};

        reset_n = 1'b0;
        vblank  = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        a0 = A0;
        a1 = A1;
        d0 = D0;
        d1 = D1;

        // Reset values
        repeat (2) tick();
        chk("rst_busy", 32'(busy_4), 32'(0));
        chk("rst_we", 32'(we_4), 32'(0));
        chk("rst_fw", 32'(fw_4), 32'(0));
        chk("rst_ready", 32'({r0_4, r1_4, r0_1, r1_1}), 32'(0));
        chk("rst_addr", 32'(addr_4), 32'(0));
        reset_n = 1'b1;

        // Vector table: window opens, burst-limited arbitration, drop of req1, close
        ea4 = '0; ed4 = '0; ea1 = '0; ed1 = '0;
        pg4 = 0; pg1 = 0;
        for (int i = 0; i < NV; i++) begin
            tick();
            vblank = (vt[i].vb != 0);
            v0     = (vt[i].rv0 != 0);
            v1     = (vt[i].rv1 != 0);
            smp();
            if (pg4 == 1) begin ea4 = A0; ed4 = D0; end
            if (pg4 == 2) begin ea4 = A1; ed4 = D1; end
            if (pg1 == 1) begin ea1 = A0; ed1 = D0; end
            if (pg1 == 2) begin ea1 = A1; ed1 = D1; end
            chk($sformatf("v%0d_busy", i), 32'({busy_4, busy_1}), 32'({2{vt[i].bsy != 0}}));
            chk($sformatf("v%0d_rdy4", i), 32'({r0_4, r1_4}), 32'({vt[i].g4 == 1, vt[i].g4 == 2}));
            chk($sformatf("v%0d_rdy1", i), 32'({r0_1, r1_1}), 32'({vt[i].g1 == 1, vt[i].g1 == 2}));
            chk($sformatf("v%0d_we4", i), 32'(we_4), 32'(pg4 != 0));
            chk($sformatf("v%0d_we1", i), 32'(we_1), 32'(pg1 != 0));
            chk($sformatf("v%0d_wr4", i), {addr_4, data_4}, {ea4, ed4});
            chk($sformatf("v%0d_wr1", i), {addr_1, data_1}, {ea1, ed1});
            pg4 = vt[i].g4;
            pg1 = vt[i].g1;
        end
        chk("tbl_fw4", 32'(fw_4), 32'(24));
        chk("tbl_fw1", 32'(fw_1), 32'(24));

        // 37 req1 writes in one window
        tick();
        vblank = 1'b1;
        v1 = 1'b1;
        repeat (2) tick();
        bad = 0;
        for (int k = 0; k < 37; k++) begin
            smp();
            if (!(r1_4 && r1_1)) bad++;
            tick();
        end
        v1 = 1'b0;
        vblank = 1'b0;
        chk("f37_ready_gaps", 32'(bad), 32'(0));
        smp();
        chk("f37_fw_prev", 32'(fw_4), 32'(24));
        tick();
        smp();
        chk("f37_fw_1cyc", 32'(fw_4), 32'(24));
        chk("f37_busy_1cyc", 32'(busy_4), 32'(1));
        tick();
        smp();
        chk("f37_fw4", 32'(fw_4), 32'(37));
        chk("f37_fw1", 32'(fw_1), 32'(37));
        chk("f37_busy", 32'(busy_4), 32'(0));

        // Empty window
        tick();
        vblank = 1'b1;
        repeat (5) tick();
        vblank = 1'b0;
        repeat (2) tick();
        smp();
        chk("f0_fw4", 32'(fw_4), 32'(0));
        chk("f0_fw1", 32'(fw_1), 32'(0));

        // Write accepted on the closing edge; late request waits for the next window
        tick();
        vblank = 1'b1;
        repeat (2) tick();
        tick();
        vblank = 1'b0;
        tick();
        v0 = 1'b1;
        smp();
        chk("ce_busy", 32'(busy_4), 32'(1));
        chk("ce_ready", 32'({r0_4, r0_1}), 32'(2'b11));
        tick();
        v0 = 1'b0;
        v1 = 1'b1;
        smp();
        chk("ce_we", 32'({we_4, we_1}), 32'(2'b11));
        chk("ce_addr", 32'(addr_4), 32'(A0));
        chk("ce_closed", 32'(busy_4), 32'(0));
        chk("ce_fw4", 32'(fw_4), 32'(1));
        chk("ce_fw1", 32'(fw_1), 32'(1));
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            smp();
            if (r1_4 || r1_1 || we_4 || we_1) bad++;
            tick();
        end
        chk("late_blocked", 32'(bad), 32'(0));
        vblank = 1'b1;
        tick();
        smp();
        chk("late_wait", 32'({r1_4, r1_1}), 32'(0));
        tick();
        smp();
        chk("late_served", 32'({r0_4, r1_4, r0_1, r1_1}), 32'(4'b0101));
        tick();
        v1 = 1'b0;
        smp();
        chk("late_write", {addr_4, data_4}, {A1, D1});
        chk("late_we", 32'({we_4, we_1}), 32'(2'b11));

        // Asynchronous reset mid-window with both requesters valid
        tick();
        v0 = 1'b1;
        v1 = 1'b1;
        repeat (2) tick();
        smp();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_we", 32'({we_4, we_1}), 32'(0));
        chk("mrst_busy", 32'({busy_4, busy_1}), 32'(0));
        chk("mrst_ready", 32'({r0_4, r1_4, r0_1, r1_1}), 32'(0));
        chk("mrst_fw", 32'(fw_4), 32'(0));
        chk("mrst_addr", 32'(addr_4), 32'(0));
        tick();
        reset_n = 1'b1;
        smp();
        chk("mrst_hold", 32'({busy_4, r0_4, r1_4}), 32'(0));
        repeat (2) tick();
        smp();
        chk("mrst_first4", 32'({r0_4, r1_4}), 32'(2'b10));
        chk("mrst_first1", 32'({r0_1, r1_1}), 32'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
